// File: rtl/packet_assembler_fifo.sv
// HDMI data-island packet assembler: FIFO-buffered packets serialised per 32-pixel slot with BCH ECC.
// Optional PACKET_ASM_STATS_EN adds saturating sent/null slot counters.
module packet_assembler_fifo #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  ECC_POLY = 8'h83
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [23:0]              in_header,
    input  logic [223:0]             in_sub,
    input  logic                     data_island_period,
    output logic [8:0]               packet_data,
    output logic [4:0]               counter,
    output logic                     packet_is_null,
    output logic                     abort,
    output logic [$clog2(DEPTH):0]   fill_level
`ifdef PACKET_ASM_STATS_EN
    ,
    output logic [15:0]              sent_count,
    output logic [15:0]              null_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [223:0] sub;
        logic [23:0]  header;
    } pkt_t;

    pkt_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    pkt_t             cur;
    logic             cur_valid;
    logic [7:0]       hdr_par;
    logic [3:0][7:0]  sub_par;
    logic [31:0]      hdr_blk;
    logic [3:0][63:0] sub_blk;
    logic             push;
    logic             pop;
    logic             slot_end;
    logic             drop;

    function automatic logic [7:0] bch_step(input logic [7:0] p, input logic b);
        return (p >> 1) ^ ((p[0] ^ b) ? ECC_POLY : 8'h00);
    endfunction

    assign push       = in_valid && in_ready;
    assign slot_end   = data_island_period && (counter == 5'd31);
    assign drop       = !data_island_period && (counter != 5'd0);
    // Outside the island an empty working register refills at once; inside only at slot end.
    assign pop        = (count != '0) && (data_island_period ? slot_end : !cur_valid);
    assign count_next = count + CW'(push) - CW'(pop);

    assign fill_level     = count;
    assign packet_is_null = !cur_valid;

    // FIFO storage
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem[wr_ptr] <= pkt_t'({in_sub, in_header});
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            in_ready <= (count_next < CW'(DEPTH));
        end
    end

    // Working register; contents forced to zero whenever it holds no packet
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cur       <= '0;
            cur_valid <= 1'b0;
        end else if (pop) begin
            cur       <= mem[rd_ptr];
            cur_valid <= 1'b1;
        end else if (slot_end || drop) begin
            cur       <= '0;
            cur_valid <= 1'b0;
        end
    end

    // Slot counter and abort pulse
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter <= '0;
            abort   <= 1'b0;
        end else begin
            counter <= data_island_period ? counter + 5'd1 : 5'd0;
            abort   <= drop;
        end
    end

    always_comb begin
        hdr_blk = {hdr_par, cur.header};
        sub_blk = '0;
        for (int i = 0; i < 4; i++) begin
            sub_blk[i] = {sub_par[i], cur.sub[56*i +: 56]};
        end
    end

    always_comb begin
        packet_data    = '0;
        packet_data[0] = hdr_blk[counter];
        for (int i = 0; i < 4; i++) begin
            packet_data[1+i] = sub_blk[i][{counter, 1'b0}];
            packet_data[5+i] = sub_blk[i][{counter, 1'b1}];
        end
    end

    // BCH parity accumulates over the data bits, then holds while it is shifted out
    always_ff @(posedge clk_pixel) begin
        if (reset || !data_island_period || counter == 5'd31) begin
            hdr_par <= '0;
            sub_par <= '0;
        end else begin
            if (counter < 5'd24) begin
                hdr_par <= bch_step(hdr_par, hdr_blk[counter]);
            end
            if (counter < 5'd28) begin
                for (int i = 0; i < 4; i++) begin
                    sub_par[i] <= bch_step(bch_step(sub_par[i], sub_blk[i][{counter, 1'b0}]),
                                           sub_blk[i][{counter, 1'b1}]);
                end
            end
        end
    end

`ifdef PACKET_ASM_STATS_EN
    // Completed-slot statistics; aborted slots never reach slot end
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            sent_count <= '0;
            null_count <= '0;
        end else if (slot_end) begin
            if (cur_valid && sent_count != 16'hFFFF) begin
                sent_count <= sent_count + 16'd1;
            end
            if (!cur_valid && null_count != 16'hFFFF) begin
                null_count <= null_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_packet_assembler_fifo.sv
// Directed self-checking bench for packet_assembler_fifo (DEPTH=4).
module tb_packet_assembler_fifo;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [23:0]  in_header;
    logic [223:0] in_sub;
    logic         data_island_period;
    logic [8:0]   packet_data;
    logic [4:0]   counter;
    logic         packet_is_null;
    logic         abort;
    logic [2:0]   fill_level;
`ifdef PACKET_ASM_STATS_EN
    logic [15:0]  sent_count;
    logic [15:0]  null_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    packet_assembler_fifo #(.DEPTH(4), .ECC_POLY(8'h83)) dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_header          (in_header),
        .in_sub             (in_sub),
        .data_island_period (data_island_period),
        .packet_data        (packet_data),
        .counter            (counter),
        .packet_is_null     (packet_is_null),
        .abort              (abort),
        .fill_level         (fill_level)
`ifdef PACKET_ASM_STATS_EN
        ,
        .sent_count         (sent_count),
        .null_count         (null_count)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bch(input logic [55:0] d, input int n);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < n; i++) begin
            p = (p >> 1) ^ ((p[0] ^ d[i]) ? 8'h83 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [8:0] exp_pd(input logic [23:0] h, input logic [223:0] s, input int c);
        logic [31:0] hb;
        logic [63:0] sb;
        logic [55:0] sd;
        logic [8:0]  r = '0;
        hb   = {bch({32'h0, h}, 24), h};
        r[0] = hb[c];
        for (int i = 0; i < 4; i++) begin
            sd       = s[56*i +: 56];
            sb       = {bch(sd, 56), sd};
            r[1+i]   = sb[2*c];
            r[5+i]   = sb[2*c+1];
        end
        return r;
    endfunction

    // One full 32-cycle slot, island held high throughout
    task automatic run_slot(input string tag, input logic [23:0] h, input logic [223:0] s,
                            input logic is_null);
        data_island_period = 1'b1;
        for (int k = 0; k < 32; k++) begin
            check({tag, "_counter"}, 32'(counter), 32'(k));
            check({tag, "_pd"}, 32'(packet_data), 32'(exp_pd(h, s, k)));
            check({tag, "_null"}, 32'(packet_is_null), 32'(is_null));
            tick();
        end
    endtask

    logic [23:0]  hq [5];
    logic [223:0] sq [5];
    logic [7:0]   par_hand;
    int           xfers;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_header = '0; in_sub = '0; data_island_period = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        check("rst_counter",  32'(counter), 32'd0);
        check("rst_ready",    32'(in_ready), 32'd1);
        check("rst_fill",     32'(fill_level), 32'd0);
        check("rst_pd",       32'(packet_data), 32'h000);
        check("rst_null",     32'(packet_is_null), 32'd1);
        check("rst_abort",    32'(abort), 32'd0);

        // single header-bit packet: hand-computed parity 8'h4A shifted out LSB first
        in_valid = 1'b1; in_header = 24'h000001; in_sub = '0;
        tick();
        in_valid = 1'b0;
        check("p1_fill_fifo", 32'(fill_level), 32'd1);
        check("p1_null_pre",  32'(packet_is_null), 32'd1);
        tick();
        check("p1_fill_cur",  32'(fill_level), 32'd0);
        check("p1_null_cur",  32'(packet_is_null), 32'd0);
        par_hand = 8'h4A;
        data_island_period = 1'b1;
        for (int k = 0; k < 32; k++) begin
            check("p1_counter", 32'(counter), 32'(k));
            if (k == 0)
                check("p1_pd0", 32'(packet_data), 32'h001);
            else if (k < 24)
                check("p1_pdhdr", 32'(packet_data), 32'h000);
            else
                check("p1_pdpar", 32'(packet_data), 32'(par_hand[k-24]));
            tick();
        end

        // empty FIFO: null slot
        run_slot("null", 24'h0, 224'h0, 1'b1);
        data_island_period = 1'b0;
`ifdef PACKET_ASM_STATS_EN
        check("stat_sent", 32'(sent_count), 32'd1);
        check("stat_null", 32'(null_count), 32'd1);
`endif
        tick();
        check("null_abort", 32'(abort), 32'd0);

        // three back-to-back packets
        hq[0] = 24'hABCDEF; sq[0] = {56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h00FF00FF00FF00, 56'h8000000000001};
        hq[1] = 24'h123456; sq[1] = {56'hFFFFFFFFFFFFFF, 56'h0, 56'h55555555555555, 56'hAAAAAAAAAAAAAA};
        hq[2] = 24'h800081; sq[2] = {56'h13579BDF02468A, 56'hDEADBEEFCAFE00, 56'h1, 56'h80000000000000};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_header = hq[i]; in_sub = sq[i];
            tick();
        end
        in_valid = 1'b0;
        check("m3_fill", 32'(fill_level), 32'd2);
        for (int i = 0; i < 3; i++) begin
            run_slot("m3", hq[i], sq[i], 1'b0);
        end
        data_island_period = 1'b0;
        check("m3_fill_end", 32'(fill_level), 32'd0);
        check("m3_null_end", 32'(packet_is_null), 32'd1);
        tick();

        // capacity: DEPTH+1 packets, then back-pressure
        xfers = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_header = 24'h100 + 24'(xfers);
            in_sub    = {56'(xfers), 56'hC0FFEE, 56'(i), 56'h5A5A5A5A5A5A5A};
            if (in_ready) begin
                hq[xfers] = in_header; sq[xfers] = in_sub;
                xfers++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("cap_xfers", 32'(xfers), 32'd5);
        check("cap_ready", 32'(in_ready), 32'd0);
        check("cap_fill",  32'(fill_level), 32'd4);
        run_slot("cap", hq[0], sq[0], 1'b0);
        data_island_period = 1'b0;
        check("cap_ready_back", 32'(in_ready), 32'd1);
        check("cap_fill_pop",   32'(fill_level), 32'd3);

        // abort at counter 10, then the next FIFO packet with fresh parity
        data_island_period = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("ab_pd", 32'(packet_data), 32'(exp_pd(hq[1], sq[1], k)));
            tick();
        end
        check("ab_counter10", 32'(counter), 32'd10);
        check("ab_abort_pre", 32'(abort), 32'd0);
        data_island_period = 1'b0;
        tick();
        check("ab_abort",   32'(abort), 32'd1);
        check("ab_counter", 32'(counter), 32'd0);
        check("ab_null",    32'(packet_is_null), 32'd1);
        tick();
        check("ab_abort_end", 32'(abort), 32'd0);
        check("ab_reload",    32'(packet_is_null), 32'd0);
        check("ab_fill",      32'(fill_level), 32'd2);
        run_slot("ab_next", hq[2], sq[2], 1'b0);
        data_island_period = 1'b0;
        check("ab_fill_end", 32'(fill_level), 32'd1);

        // reset mid-operation drops queued packets
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_fill",  32'(fill_level), 32'd0);
        check("mr_null",  32'(packet_is_null), 32'd1);
        check("mr_ready", 32'(in_ready), 32'd1);
        check("mr_pd",    32'(packet_data), 32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
